// File: rtl/int_ctrl.sv
// Interrupt controller on the 16-bit peripheral bus: latches pending edges, masks them and drives one
// prioritised request to the CPU. Read data is 1 cycle late. The bus never stalls; an open request waits for ack/EOI.
module int_ctrl #(
    parameter logic [15:0] BASE_ADDR = 16'h0430,
    parameter int          N_SRC     = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [15:0]      i_addr,
    input  logic [15:0]      i_data,
    output logic [15:0]      o_data,
    input  logic [N_SRC-1:0] i_irq,
    input  logic             i_ack,
    output logic             o_irq,
    output logic [3:0]       o_vector
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ASSERT  = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic [N_SRC-1:0] irq_q, pend_q, pend_d, en_q, en_d;
    logic             ctrl_q, ctrl_d;
    logic [1:0]       state_q, state_d;
    logic [3:0]       vec_q, vec_d;
    logic             irq_out_q, irq_out_d;
    logic [15:0]      rdata_q, rdata_d;

    logic [15:0]      off;
    logic             sel, wr_pend, wr_en, wr_stat, wr_ctrl;
    logic [N_SRC-1:0] edge_set, pend_w, req, ack_clr;
    logic [15:0]      pend_w16, en_d16, pend_q16, en_q16;
    logic             cand_vld, ack_take;
    logic [3:0]       cand_id;
    logic             unused_data;

    // Subtraction in 16 bits makes the register window wrap around address 0.
    assign off     = i_addr - BASE_ADDR;
    assign sel     = (off[15:2] == 14'd0);
    assign wr_pend = i_we && sel && (off[1:0] == 2'd0);
    assign wr_en   = i_we && sel && (off[1:0] == 2'd1);
    assign wr_stat = i_we && sel && (off[1:0] == 2'd2);
    assign wr_ctrl = i_we && sel && (off[1:0] == 2'd3);
    assign unused_data = ^i_data;

    assign edge_set = i_irq & ~irq_q;
    assign pend_w   = (wr_pend ? (pend_q & ~i_data[N_SRC-1:0]) : pend_q) | edge_set;
    assign en_d     = wr_en ? i_data[N_SRC-1:0] : en_q;
    assign ctrl_d   = wr_ctrl ? i_data[0] : ctrl_q;
    assign req      = pend_q & en_q & {N_SRC{ctrl_q}};

    always_comb begin
        pend_w16 = '0;
        en_d16   = '0;
        pend_q16 = '0;
        en_q16   = '0;
        pend_w16[N_SRC-1:0] = pend_w;
        en_d16[N_SRC-1:0]   = en_d;
        pend_q16[N_SRC-1:0] = pend_q;
        en_q16[N_SRC-1:0]   = en_q;
    end

    always_comb begin
        cand_vld = 1'b0;
        cand_id  = 4'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                cand_vld = 1'b1;
                cand_id  = i[3:0];
            end
        end
    end

    // Withdrawal looks at this cycle's bus writes so a clear beats a same-cycle ack.
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        irq_out_d = irq_out_q;
        ack_take  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cand_vld) begin
                    state_d   = ST_ASSERT;
                    vec_d     = cand_id;
                    irq_out_d = 1'b1;
                end
            end
            ST_ASSERT: begin
                if (!(pend_w16[vec_q] && en_d16[vec_q] && ctrl_d)) begin
                    state_d   = ST_IDLE;
                    vec_d     = 4'd0;
                    irq_out_d = 1'b0;
                end else if (i_ack) begin
                    state_d   = ST_SERVICE;
                    irq_out_d = 1'b0;
                    ack_take  = 1'b1;
                end
            end
            ST_SERVICE: begin
                if (wr_stat) begin
                    state_d = ST_IDLE;
                    vec_d   = 4'd0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                vec_d     = 4'd0;
                irq_out_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            ack_clr[i] = ack_take && (vec_q == i[3:0]);
        end
    end

    // A fresh edge re-sets a bit even when it is cleared in the same cycle.
    assign pend_d = (pend_w & ~ack_clr) | edge_set;

    always_comb begin
        rdata_d = rdata_q;
        if (!i_we) begin
            rdata_d = 16'd0;
            if (sel) begin
                case (off[1:0])
                    2'd0:    rdata_d = pend_q16;
                    2'd1:    rdata_d = en_q16;
                    2'd2:    rdata_d = {state_q, 10'd0, vec_q};
                    default: rdata_d = {15'd0, ctrl_q};
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            irq_q     <= '0;
            pend_q    <= '0;
            en_q      <= '0;
            ctrl_q    <= 1'b0;
            state_q   <= ST_IDLE;
            vec_q     <= 4'd0;
            irq_out_q <= 1'b0;
            rdata_q   <= 16'd0;
        end else begin
            irq_q     <= i_irq;
            pend_q    <= pend_d;
            en_q      <= en_d;
            ctrl_q    <= ctrl_d;
            state_q   <= state_d;
            vec_q     <= vec_d;
            irq_out_q <= irq_out_d;
            rdata_q   <= rdata_d;
        end
    end

    assign o_irq    = irq_out_q;
    assign o_vector = vec_q;
    assign o_data   = rdata_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: expectations are queued with a target cycle and a monitor compares them.
module tb_int_ctrl;

    localparam logic [15:0] A_PEND = 16'h0430;
    localparam logic [15:0] A_EN   = 16'h0431;
    localparam logic [15:0] A_STAT = 16'h0432;
    localparam logic [15:0] A_CTRL = 16'h0433;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_we = 1'b0;
    logic [15:0] i_addr = 16'd0;
    logic [15:0] i_data = 16'd0;
    logic [15:0] o_data;
    logic [7:0]  i_irq = 8'd0;
    logic        i_ack = 1'b0;
    logic        o_irq;
    logic [3:0]  o_vector;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];

    int_ctrl #(.BASE_ADDR(16'h0430), .N_SRC(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_we(i_we), .i_addr(i_addr), .i_data(i_data),
        .o_data(o_data), .i_irq(i_irq), .i_ack(i_ack), .o_irq(o_irq), .o_vector(o_vector)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // kind: 0 = o_data, 1 = o_irq, 2 = o_vector
    always @(negedge i_clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                logic [15:0] act;
                case (sb[i].kind)
                    0:       act = o_data;
                    1:       act = {15'd0, o_irq};
                    default: act = {12'd0, o_vector};
                endcase
                n_checks = n_checks + 1;
                if (act !== sb[i].exp) begin
                    n_errors = n_errors + 1;
                    $display("FAIL %s: got %h expected %h (cycle %0d)", sb[i].name, act, sb[i].exp, cyc);
                end
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic expect_at(input int d, input int kind, input logic [15:0] e, input string nm);
        exp_t t;
        t.cyc  = cyc + d;
        t.kind = kind;
        t.exp  = e;
        t.name = nm;
        sb.push_back(t);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        i_we = 1'b1; i_addr = a; i_data = d;
        tick();
        i_we = 1'b0; i_addr = 16'd0; i_data = 16'd0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] e, input string nm);
        i_we = 1'b0; i_addr = a;
        expect_at(1, 0, e, nm);
        tick();
        i_addr = 16'd0;
    endtask

    task automatic pulse(input logic [7:0] m);
        i_irq = m;
        tick();
        i_irq = 8'd0;
    endtask

    task automatic ack();
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
    endtask

    task automatic check_now(input string nm, input logic [15:0] act, input logic [15:0] e);
        n_checks = n_checks + 1;
        if (act !== e) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h", nm, act, e);
        end
    endtask

    initial begin
        repeat (2) tick();
        check_now("rst_irq", {15'd0, o_irq}, 16'h0000);
        check_now("rst_vector", {12'd0, o_vector}, 16'h0000);
        check_now("rst_data", o_data, 16'h0000);
        i_rst_n = 1'b1;
        tick();
        rd(A_STAT, 16'h0000, "rst_stat");
        rd(A_CTRL, 16'h0000, "rst_ctrl");

        // 1: single source, latency and STAT encoding
        wr(A_EN, 16'h0001);
        wr(A_CTRL, 16'h0001);
        expect_at(1, 1, 16'h0000, "t1_irq_not_yet");
        pulse(8'h01);
        expect_at(1, 1, 16'h0001, "t1_irq");
        expect_at(1, 2, 16'h0000, "t1_vector");
        tick();
        rd(A_STAT, 16'h4000, "t1_stat_assert");
        ack();
        rd(A_STAT, 16'h8000, "t1_stat_service");
        rd(A_PEND, 16'h0000, "t1_pend_cleared");
        wr(A_STAT, 16'h0000);
        rd(A_STAT, 16'h0000, "t1_stat_idle");

        // 2: priority and EOI re-arbitration
        wr(A_EN, 16'h00FF);
        pulse(8'h0A);
        expect_at(1, 2, 16'h0001, "t2_vector1");
        expect_at(1, 1, 16'h0001, "t2_irq");
        tick();
        ack();
        expect_at(1, 1, 16'h0000, "t2_irq_service");
        rd(A_STAT, 16'h8001, "t2_stat_service");
        rd(A_PEND, 16'h0008, "t2_pend");
        wr(A_STAT, 16'h0000);
        expect_at(1, 2, 16'h0003, "t2_vector3");
        expect_at(1, 1, 16'h0001, "t2_irq3");
        tick();
        ack();
        wr(A_STAT, 16'h0000);
        expect_at(1, 1, 16'h0000, "t2_idle_irq");
        expect_at(2, 1, 16'h0000, "t2_idle_irq2");

        // 3: masked source waits for its enable
        wr(A_EN, 16'h00FB);
        pulse(8'h04);
        expect_at(1, 1, 16'h0000, "t3_masked_a");
        expect_at(3, 1, 16'h0000, "t3_masked_b");
        repeat (3) tick();
        wr(A_EN, 16'h0004);
        expect_at(1, 1, 16'h0001, "t3_irq");
        expect_at(1, 2, 16'h0002, "t3_vector2");
        tick();

        // 4: W1C withdrawal beats a same-cycle ack
        i_we = 1'b1; i_addr = A_PEND; i_data = 16'h0004; i_ack = 1'b1;
        expect_at(1, 1, 16'h0000, "t4_irq_dropped");
        expect_at(1, 2, 16'h0000, "t4_vector_idle");
        tick();
        i_we = 1'b0; i_addr = 16'd0; i_data = 16'd0; i_ack = 1'b0;
        rd(A_STAT, 16'h0000, "t4_stat_idle");
        rd(A_PEND, 16'h0000, "t4_pend");

        // 5: level held high sets once; set wins over coincident W1C; register width limits
        wr(A_CTRL, 16'h0000);
        i_irq = 8'h01;
        tick();
        tick();
        i_we = 1'b1; i_addr = A_PEND; i_data = 16'h0001;
        tick();
        i_we = 1'b0; i_addr = 16'd0; i_data = 16'd0;
        repeat (8) tick();
        rd(A_PEND, 16'h0000, "t5_level_once");
        i_irq = 8'h00;
        tick();
        i_irq = 8'h01; i_we = 1'b1; i_addr = A_PEND; i_data = 16'h0001;
        tick();
        i_irq = 8'h00; i_we = 1'b0; i_addr = 16'd0; i_data = 16'd0;
        rd(A_PEND, 16'h0001, "t5_set_wins");
        wr(A_EN, 16'hFFFF);
        rd(A_EN, 16'h00FF, "t5_en_width");
        wr(A_CTRL, 16'hFFFF);
        rd(A_CTRL, 16'h0001, "t5_ctrl_width");
        wr(A_CTRL, 16'h0000);
        rd(16'h0434, 16'h0000, "t5_unmapped_hi");
        rd(A_EN, 16'h00FF, "t5_en_again");
        rd(16'h042F, 16'h0000, "t5_unmapped_lo");

        // 6: asynchronous reset while in service
        wr(A_PEND, 16'h00FF);
        wr(A_EN, 16'h0020);
        wr(A_CTRL, 16'h0001);
        pulse(8'h20);
        expect_at(1, 2, 16'h0005, "t6_vector5");
        tick();
        ack();
        rd(A_STAT, 16'h8005, "t6_stat_service");
        tick();
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_now("t6_async_irq", {15'd0, o_irq}, 16'h0000);
        check_now("t6_async_vector", {12'd0, o_vector}, 16'h0000);
        check_now("t6_async_data", o_data, 16'h0000);
        tick();
        i_rst_n = 1'b1;
        rd(A_PEND, 16'h0000, "t6_pend_rst");
        rd(A_EN, 16'h0000, "t6_en_rst");
        rd(A_STAT, 16'h0000, "t6_stat_rst");

        for (int k = 0; k < 10 && sb.size() > 0; k++) tick();
        while (sb.size() > 0) begin
            n_checks = n_checks + 1;
            n_errors = n_errors + 1;
            $display("FAIL %s: never compared, expected %h", sb[0].name, sb[0].exp);
            void'(sb.pop_front());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
